// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth digit decoder: {H,D} digit codes and FSM states.
package booth_pkg;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b11;
  localparam logic [1:0] DIG_ILL  = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

endpackage

// File: rtl/booth_acc_unit.sv
// Combinational accumulate step: folds one signed digit at weight 2^idx into acc (mod 2^WIDTH).
module booth_acc_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [IDXW-1:0]  idx,
  input  logic             h,
  input  logic             d,
  output logic [WIDTH-1:0] acc_next,
  output logic             illegal
);
  import booth_pkg::*;

  logic [WIDTH-1:0] weight;

  assign weight = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

  always_comb begin
    acc_next = acc;
    illegal  = 1'b0;
    unique case ({h, d})
      DIG_POS:  acc_next = acc + weight;
      DIG_NEG:  acc_next = acc - weight;
      DIG_ILL:  illegal  = 1'b1;
      default:  acc_next = acc;
    endcase
  end

endmodule

// File: rtl/booth_digit_decoder.sv
// Serial radix-2 Booth digit stream decoder: rebuilds a WIDTH-bit two's-complement word
// from LSB-first (H,D) digits and presents it on a valid/ready output.
module booth_digit_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic             digit_h,
  input  logic             digit_d,
  input  logic             digit_last,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_err
);
  import booth_pkg::*;

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [IDXW-1:0]  idx;
  logic             err;
  logic             illegal;
  logic             accept;
  logic             closing;

  booth_acc_unit #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_acc (
    .acc      (acc),
    .idx      (idx),
    .h        (digit_h),
    .d        (digit_d),
    .acc_next (acc_next),
    .illegal  (illegal)
  );

  assign accept  = digit_valid & digit_ready;
  // acc and idx are zero in IDLE, so the first digit uses the same update path as the rest.
  assign closing = digit_last | (idx == IDXW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      err         <= 1'b0;
      digit_ready <= 1'b1;
      word_valid  <= 1'b0;
      word        <= '0;
      word_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            err <= err | illegal;
            idx <= idx + IDXW'(1);
            if (closing) begin
              state       <= HOLD;
              digit_ready <= 1'b0;
              word_valid  <= 1'b1;
              word        <= acc_next;
              word_err    <= err | illegal;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (word_ready) begin
            state       <= IDLE;
            acc         <= '0;
            idx         <= '0;
            err         <= 1'b0;
            digit_ready <= 1'b1;
            word_valid  <= 1'b0;
            word        <= '0;
            word_err    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Self-checking bench for booth_digit_decoder against an arithmetic Booth encode/decode model.
module tb_booth_digit_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         digit_valid = 1'b0;
  logic         digit_ready;
  logic         digit_h = 1'b0;
  logic         digit_d = 1'b0;
  logic         digit_last = 1'b0;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [W-1:0] word;
  logic         word_err;

  int total = 0;
  int bad = 0;
  int timeouts = 0;

  always #5 clk = ~clk;

  booth_digit_decoder #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_h     (digit_h),
    .digit_d     (digit_d),
    .digit_last  (digit_last),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word        (word),
    .word_err    (word_err)
  );

  // Radix-2 Booth digit i of v: b[i-1] - b[i], with b[-1] = 0.
  function automatic int booth_digit(input int v, input int i);
    int prev;
    prev = (i == 0) ? 0 : ((v >> (i - 1)) & 1);
    return prev - ((v >> i) & 1);
  endfunction

  // Drive one raw {h,d} code; returns after the accepting rising edge.
  task automatic put_raw(input logic h, input logic d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    digit_valid = 1'b1;
    digit_h     = h;
    digit_d     = d;
    digit_last  = last;
    while (digit_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeouts++;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic put_digit(input int dig, input logic last);
    put_raw(dig != 0, dig < 0, last);
  endtask

  task automatic consume();
    @(negedge clk);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid got=%0b want=0", word_valid); end
    total++; if (word !== '0) begin bad++; $display("FAIL reset_word got=%0h want=0", word); end
    total++; if (word_err !== 1'b0) begin bad++; $display("FAIL reset_word_err got=%0b want=0", word_err); end
    total++; if (digit_ready !== 1'b1) begin bad++; $display("FAIL reset_digit_ready got=%0b want=1", digit_ready); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        total++;
        if (word_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%0b want=0", word_valid); end
      end
      put_digit(booth_digit(8'h5A, i), i == W - 1);
    end
    @(negedge clk);
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL full_latency got=%0b want=1", word_valid); end
    total++; if (word !== 8'h5A) begin bad++; $display("FAIL full_word got=%0h want=5a", word); end
    total++; if (word_err !== 1'b0) begin bad++; $display("FAIL full_err got=%0b want=0", word_err); end
    consume();
    @(negedge clk);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL full_release got=%0b want=0", word_valid); end
  endtask

  task automatic test_short_frames();
    put_digit(-1, 1'b1);
    @(negedge clk);
    total++; if (word_valid !== 1'b1 || word !== 8'hFF) begin
      bad++; $display("FAIL short_ff got=%0b/%0h want=1/ff", word_valid, word); end
    consume();
    for (int i = 0; i < W; i++) put_digit((i == W - 1) ? -1 : 0, i == W - 1);
    @(negedge clk);
    total++; if (word_valid !== 1'b1 || word !== 8'h80) begin
      bad++; $display("FAIL short_80 got=%0b/%0h want=1/80", word_valid, word); end
    consume();
  endtask

  task automatic test_illegal();
    int exp;
    exp = 0;
    // Digit 3 of 0x5A (-1) replaced by the illegal code, which decodes as 0.
    for (int i = 0; i < W; i++) begin
      if (i == 3) put_raw(1'b0, 1'b1, 1'b0);
      else begin
        put_digit(booth_digit(8'h5A, i), i == W - 1);
        exp += booth_digit(8'h5A, i) * (1 << i);
      end
    end
    exp &= 8'hFF;
    @(negedge clk);
    total++; if (word !== exp[W-1:0]) begin bad++; $display("FAIL ill_word got=%0h want=%0h", word, exp[W-1:0]); end
    total++; if (word_err !== 1'b1) begin bad++; $display("FAIL ill_err got=%0b want=1", word_err); end
    consume();
    for (int i = 0; i < W; i++) put_digit(booth_digit(8'h5A, i), i == W - 1);
    @(negedge clk);
    total++; if (word !== 8'h5A || word_err !== 1'b0) begin
      bad++; $display("FAIL ill_clean got=%0h/%0b want=5a/0", word, word_err); end
    consume();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < W; i++) put_digit(booth_digit(8'h3C, i), i == W - 1);
    @(negedge clk);
    digit_valid = 1'b1; digit_h = 1'b1; digit_d = 1'b1; digit_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++; if (digit_ready !== 1'b0 || word_valid !== 1'b1 || word !== 8'h3C) begin
        bad++; $display("FAIL hold_c%0d ready/valid/word got=%0b/%0b/%0h want=0/1/3c",
                        c, digit_ready, word_valid, word); end
      @(negedge clk);
    end
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0; digit_valid = 1'b0; digit_last = 1'b0;
    @(negedge clk);
    total++; if (digit_ready !== 1'b1 || word_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=%0b/%0b want=1/0", digit_ready, word_valid); end
    for (int i = 0; i < W; i++) put_digit(booth_digit(8'h21, i), i == W - 1);
    @(negedge clk);
    total++; if (word !== 8'h21 || word_err !== 1'b0) begin
      bad++; $display("FAIL hold_next got=%0h/%0b want=21/0", word, word_err); end
    consume();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 4; i++) put_digit(booth_digit(8'h5A, i), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (word_valid !== 1'b0 || word !== '0 || word_err !== 1'b0 || digit_ready !== 1'b1) begin
      bad++; $display("FAIL midrst valid/word/err/ready got=%0b/%0h/%0b/%0b want=0/0/0/1",
                      word_valid, word, word_err, digit_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++) put_digit(booth_digit(8'h01, i), i == W - 1);
    @(negedge clk);
    total++; if (word_valid !== 1'b1 || word !== 8'h01) begin
      bad++; $display("FAIL midrst_next got=%0b/%0h want=1/01", word_valid, word); end
    consume();
  endtask

  task automatic test_random();
    int v, hi, len;
    logic last_on_top;
    for (int f = 0; f < 1000; f++) begin
      v = int'($urandom_range(0, 255));
      hi = -1;
      for (int i = 0; i < W; i++) if (booth_digit(v, i) != 0) hi = i;
      len = int'($urandom_range(hi + 1, W));
      if (len == 0) len = 1;
      last_on_top = (len < W) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        put_digit(booth_digit(v, i), (i == len - 1) && last_on_top);
      end
      @(negedge clk);
      total++; if (word_valid !== 1'b1 || word !== v[W-1:0] || word_err !== 1'b0) begin
        bad++; $display("FAIL rand_f%0d valid/word/err got=%0b/%0h/%0b want=1/%0h/0",
                        f, word_valid, word, word_err, v[W-1:0]); end
      consume();
    end
  endtask

  task automatic test_timeouts();
    total++; if (timeouts !== 0) begin bad++; $display("FAIL digit_ready_timeouts got=%0d want=0", timeouts); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frames();
    test_illegal();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    test_timeouts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
